// File: rtl/te_min_multiplier.sv
// Per-channel pixel x coefficient multiply, saturate/truncate, then unsigned minimum across channels.
// Coefficients are double-buffered. The shadow bank is applied at the next accepted start-of-frame beat.
module te_min_multiplier #(
    parameter int CH     = 3,
    parameter int DATA_W = 8,
    parameter int FRAC_W = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [CH*DATA_W-1:0] pc,
    input  logic                 ac_inv_load,
    input  logic [CH*FRAC_W-1:0] ac_inv_in,
    output logic                 ac_pending,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic [FRAC_W-1:0]    product
);
    localparam int STAGES = 3;
    localparam int PW     = DATA_W + FRAC_W;

    logic [STAGES:1]              r_vld_pipe;
    logic [CH*FRAC_W-1:0]         r_shadow, r_active, w_coef;
    logic                         r_pending;
    logic                         w_en, w_acc, w_sof_acc;
    logic [CH*DATA_W-1:0]         r_s1_pc;
    logic [CH*FRAC_W-1:0]         r_s1_coef;
    logic                         r_s1_sof, r_s2_sof;
    logic [CH-1:0][PW-1:0]        w_mul, r_s2_prod;
    logic [CH-1:0][FRAC_W-1:0]    w_res;
    logic [FRAC_W-1:0]            w_min;
    logic [FRAC_W-1:0]            r_product;
    logic                         r_out_sof;

    assign w_en       = !r_vld_pipe[STAGES] || out_ready;
    assign in_ready   = w_en;
    assign w_acc      = in_valid && w_en;
    assign w_sof_acc  = w_acc && in_sof;
    assign ac_pending = r_pending;
    assign out_valid  = r_vld_pipe[STAGES];
    assign product    = r_product;
    assign out_sof    = r_out_sof;

    // A load coinciding with an accepted sof beat bypasses the shadow bank into that beat.
    always_comb begin
        w_coef = r_active;
        if (w_sof_acc) begin
            if (ac_inv_load)
                w_coef = ac_inv_in;
            else if (r_pending)
                w_coef = r_shadow;
        end
    end

    // Bank updates are independent of the pipeline enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow  <= '1;
            r_active  <= '1;
            r_pending <= 1'b0;
        end else begin
            if (ac_inv_load)
                r_shadow <= ac_inv_in;
            if (w_sof_acc) begin
                r_active  <= w_coef;
                r_pending <= 1'b0;
            end else if (ac_inv_load) begin
                r_pending <= 1'b1;
            end
        end
    end

    genvar c;
    generate
        for (c = 0; c < CH; c++) begin : g_ch
            assign w_mul[c] = PW'(r_s1_pc[c*DATA_W +: DATA_W]) * PW'(r_s1_coef[c*FRAC_W +: FRAC_W]);
            if (SAT_EN) begin : g_sat
                assign w_res[c] = (|r_s2_prod[c][PW-1:FRAC_W]) ? {FRAC_W{1'b1}}
                                                               : r_s2_prod[c][FRAC_W-1:0];
            end else begin : g_trunc
                assign w_res[c] = r_s2_prod[c][FRAC_W-1:0];
            end
        end

        if (CH == 1) begin : g_bypass
            assign w_min = w_res[0];
        end else begin : g_min
            always_comb begin
                w_min = w_res[0];
                for (int k = 1; k < CH; k++)
                    if (w_res[k] < w_min)
                        w_min = w_res[k];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_pipe <= '0;
            r_s1_pc    <= '0;
            r_s1_coef  <= '0;
            r_s1_sof   <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_sof   <= 1'b0;
            r_product  <= '0;
            r_out_sof  <= 1'b0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
            r_s1_pc    <= pc;
            r_s1_coef  <= w_coef;
            r_s1_sof   <= in_sof;
            r_s2_prod  <= w_mul;
            r_s2_sof   <= r_s1_sof;
            r_product  <= w_min;
            r_out_sof  <= r_s2_sof;
        end
    end
endmodule

// File: tb/tb_te_min_multiplier.sv
// Directed scoreboard bench: the main 3-channel saturating instance plus two single-channel
// instances (saturating and truncating) fed from a shared stimulus.
module tb_te_min_multiplier;
    typedef struct packed {
        logic [15:0] prod;
        logic        sof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_sof, ac_inv_load, out_ready;
    logic [23:0] pc;
    logic [47:0] ac_inv_in;
    logic        in_ready, ac_pending, out_valid, out_sof;
    logic [15:0] product;

    logic        v1, s1, l1;
    logic [7:0]  p1;
    logic [15:0] a1;
    logic        rdyb, pendb, ovb, osofb, rdyc, pendc, ovc, osofc;
    logic [15:0] prodb, prodc;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [15:0] qb[$], qc[$];
    logic        stall_hold = 1'b0;
    logic [16:0] stall_val;

    always #5 clk = ~clk;

    te_min_multiplier #(.CH(3), .DATA_W(8), .FRAC_W(16), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .pc(pc), .ac_inv_load(ac_inv_load), .ac_inv_in(ac_inv_in), .ac_pending(ac_pending),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .product(product));

    te_min_multiplier #(.CH(1), .DATA_W(8), .FRAC_W(16), .SAT_EN(1'b1)) dut_sat1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdyb), .in_sof(s1),
        .pc(p1), .ac_inv_load(l1), .ac_inv_in(a1), .ac_pending(pendb),
        .out_valid(ovb), .out_ready(1'b1), .out_sof(osofb), .product(prodb));

    te_min_multiplier #(.CH(1), .DATA_W(8), .FRAC_W(16), .SAT_EN(1'b0)) dut_trunc1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdyc), .in_sof(s1),
        .pc(p1), .ac_inv_load(l1), .ac_inv_in(a1), .ac_pending(pendc),
        .out_valid(ovc), .out_ready(1'b1), .out_sof(osofc), .product(prodc));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference used only for the streaming test.
    function automatic logic [15:0] mdl(input logic [23:0] p, input logic [47:0] co);
        logic [23:0] m;
        logic [15:0] r, best;
        best = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            m = 24'(p[k*8 +: 8]) * 24'(co[k*16 +: 16]);
            r = (m > 24'h00FFFF) ? 16'hFFFF : m[15:0];
            if (r < best) best = r;
        end
        return best;
    endfunction

    // Output monitor for the main instance: pops on handshake, checks hold during stalls.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1) begin
            if (stall_hold)
                chk("stall_stable", 32'({out_sof, product}), 32'(stall_val));
            if (out_ready) begin
                stall_hold = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(product), 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", 32'(product), 32'(e.prod));
                    chk("out_sof", 32'(out_sof), 32'(e.sof));
                end
            end else begin
                stall_hold = 1'b1;
                stall_val  = {out_sof, product};
            end
        end else begin
            stall_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && ovb === 1'b1) begin
            if (qb.size() == 0) chk("ch1_sat_unexpected", 32'(prodb), 32'hDEAD_BEEF);
            else                chk("ch1_sat_product", 32'(prodb), 32'(qb.pop_front()));
        end
        if (rst === 1'b1 && ovc === 1'b1) begin
            if (qc.size() == 0) chk("ch1_trunc_unexpected", 32'(prodc), 32'hDEAD_BEEF);
            else                chk("ch1_trunc_product", 32'(prodc), 32'(qc.pop_front()));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [23:0] p, input logic s, input logic ld,
                        input logic [47:0] co, input logic [15:0] e);
        int n;
        in_valid = 1'b1; in_sof = s; pc = p; ac_inv_load = ld; ac_inv_in = co;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        else           sb.push_back(exp_t'{prod: e, sof: s});
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0; ac_inv_load = 1'b0;
    endtask

    task automatic load(input logic [47:0] co);
        ac_inv_load = 1'b1; ac_inv_in = co;
        @(posedge clk); #1;
        ac_inv_load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || qb.size() != 0 || qc.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(sb.size() + qb.size() + qc.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       pat [4];
        int         n, i, cyc;
        logic [23:0] sp;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; ac_inv_load = 1'b0; out_ready = 1'b1;
        pc = '0; ac_inv_in = '0; v1 = 1'b0; s1 = 1'b0; l1 = 1'b0; p1 = '0; a1 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_pending", 32'(ac_pending), 32'd0);
        rst = 1'b1;
        #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Three channels, distinct coefficients; 0x4B00 on the third edge counting acceptance
        load(48'h0180_0100_0200);
        chk("pending_after_load", 32'(ac_pending), 32'd1);
        send({8'd50, 8'd200, 8'd100}, 1'b1, 1'b0, '0, 16'h4B00);
        chk("pending_after_sof", 32'(ac_pending), 32'd0);
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd3);
        send({8'd30, 8'd20, 8'd10}, 1'b0, 1'b0, '0, 16'h1400);
        send({8'd255, 8'd255, 8'd255}, 1'b0, 1'b0, '0, 16'hFF00);

        // Single-channel saturate vs truncate, including product exactly 2^16
        v1 = 1'b1; s1 = 1'b1; l1 = 1'b1; p1 = 8'd255; a1 = 16'h0400;
        @(negedge clk);
        qb.push_back(16'hFFFF); qc.push_back(16'hFC00);
        @(posedge clk); #1;
        v1 = 1'b0; s1 = 1'b0; l1 = 1'b0;
        n = 1;
        while (!ovb && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ch1_latency", 32'(n), 32'd3);
        v1 = 1'b1; p1 = 8'd64;
        @(negedge clk);
        qb.push_back(16'hFFFF); qc.push_back(16'h0000);
        @(posedge clk); #1;
        p1 = 8'd63;
        @(negedge clk);
        qb.push_back(16'hFC00); qc.push_back(16'hFC00);
        @(posedge clk); #1;
        v1 = 1'b0;
        drain("drain_basic");

        // Load coincident with an accepted sof beat
        send({8'd200, 8'd200, 8'd200}, 1'b1, 1'b1, 48'h0080_0080_0080, 16'h6400);
        chk("pending_coincident", 32'(ac_pending), 32'd0);
        send({8'd200, 8'd200, 8'd200}, 1'b0, 1'b0, '0, 16'h6400);

        // Mid-frame loads (second overwrites first) wait for the next sof
        load(48'h0040_0040_0040);
        load(48'h0100_0100_0100);
        send({8'd200, 8'd200, 8'd200}, 1'b0, 1'b0, '0, 16'h6400);
        send({8'd200, 8'd200, 8'd200}, 1'b0, 1'b0, '0, 16'h6400);
        chk("pending_mid_frame", 32'(ac_pending), 32'd1);
        send({8'd200, 8'd200, 8'd200}, 1'b1, 1'b0, '0, 16'hC800);
        chk("pending_applied", 32'(ac_pending), 32'd0);
        send({8'd200, 8'd200, 8'd200}, 1'b1, 1'b0, '0, 16'hC800);
        drain("drain_banks");

        // Continuous stream with out_ready toggling 1,0,0,1
        i = 0; cyc = 0;
        while (i < 8 && cyc < 100) begin
            out_ready = pat[cyc % 4];
            sp = {8'd100, 8'(200 - i * 20), 8'(10 + i * 20)};
            in_valid = 1'b1; in_sof = 1'b0; pc = sp;
            @(negedge clk);
            chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (in_ready) begin
                sb.push_back(exp_t'{prod: mdl(sp, 48'h0100_0100_0100), sof: 1'b0});
                i++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain("drain_stream");

        // Reset with three beats in flight
        load(48'h0200_0200_0200);
        out_ready = 1'b0;
        send({8'd1, 8'd1, 8'd1}, 1'b0, 1'b0, '0, 16'h0100);
        send({8'd1, 8'd1, 8'd1}, 1'b0, 1'b0, '0, 16'h0100);
        send({8'd1, 8'd1, 8'd1}, 1'b0, 1'b0, '0, 16'h0100);
        #2 rst = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_product", 32'(product), 32'd0);
        chk("async_rst_pending", 32'(ac_pending), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        #1 chk("in_ready_after_pulse", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        idle(4);
        chk("no_stale_output", 32'(out_valid), 32'd0);
        send({8'd1, 8'd1, 8'd1}, 1'b0, 1'b0, '0, 16'hFFFF);
        send({8'd3, 8'd2, 8'd1}, 1'b1, 1'b0, '0, 16'hFFFF);
        drain("drain_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
